// File: rtl/trg_seq_dcd.sv
// TTC trigger decoder: registers the 3-bit encoded trigger word, decodes it into LCT/L1A/L1A_MATCH/RESYNC
// pulses, matches L1As against a local LCT history and keeps L1A / unmatched-L1A counters.
module trg_seq_dcd #(
  parameter int MAX_LAT     = 512,
  parameter int LAT_W       = 9,
  parameter int CNT_W       = 12,
  parameter int RSY_STRETCH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_enc_trg,
  input  logic             i_trg_dcd,
  input  logic             i_local_mtch,
  input  logic             i_mtch_3bx,
  input  logic [LAT_W-1:0] i_l1a_lat,
  output logic             o_lct,
  output logic             o_l1a,
  output logic             o_l1a_match,
  output logic             o_resync,
  output logic             o_code_err,
  output logic [CNT_W-1:0] o_l1a_cnt,
  output logic [CNT_W-1:0] o_nomatch_cnt
);

  localparam int IDX_W = $clog2(MAX_LAT);
  localparam int RSY_W = $clog2(RSY_STRETCH + 1);

  logic [2:0]         r_enc;
  logic [MAX_LAT-2:0] r_hist;
  logic [RSY_W-1:0]   r_rsy_cnt;

  logic               w_lct, w_l1a, w_mtch, w_rsy, w_err;
  logic [IDX_W-1:0]   w_leff, w_leff_m, w_leff_p;
  logic [MAX_LAT-1:0] w_dist;
  logic               w_hit, w_rsy_on, w_lct_o, w_l1a_o, w_mtch_o;

  always_comb begin
    w_lct = 1'b0;
    w_l1a = 1'b0;
    w_mtch = 1'b0;
    w_rsy = 1'b0;
    w_err = 1'b0;
    if (i_trg_dcd) begin
      case (r_enc)
        3'd1: w_lct = 1'b1;
        3'd2: begin w_lct = 1'b1; w_l1a = 1'b1; end
        3'd3: begin w_lct = 1'b1; w_l1a = 1'b1; w_mtch = 1'b1; end
        3'd4: w_l1a = 1'b1;
        3'd5: begin w_l1a = 1'b1; w_mtch = 1'b1; end
        3'd6: w_err = 1'b1;
        3'd7: w_rsy = 1'b1;
        default: ;
      endcase
    end else begin
      w_lct  = r_enc[0];
      w_l1a  = r_enc[1];
      w_mtch = r_enc[1];
      w_rsy  = r_enc[2];
    end
  end

  // Latency is clamped so that the +/-1 window always stays inside the history.
  always_comb begin
    if (i_l1a_lat == '0)
      w_leff = IDX_W'(1);
    else if (32'(i_l1a_lat) > 32'(MAX_LAT - 2))
      w_leff = IDX_W'(MAX_LAT - 2);
    else
      w_leff = IDX_W'(i_l1a_lat);
  end

  assign w_leff_m = w_leff - IDX_W'(1);
  assign w_leff_p = w_leff + IDX_W'(1);

  // Bit d of w_dist is an LCT d cycles ago; bit 0 is the LCT decoded this cycle.
  assign w_dist = {r_hist, w_lct};
  assign w_hit  = w_dist[w_leff] | (i_mtch_3bx & (w_dist[w_leff_m] | w_dist[w_leff_p]));

  assign w_rsy_on = w_rsy | (r_rsy_cnt != '0);
  assign w_lct_o  = w_lct & ~w_rsy_on;
  assign w_l1a_o  = w_l1a & ~w_rsy_on;
  assign w_mtch_o = w_l1a_o & (i_local_mtch ? w_hit : w_mtch);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_enc       <= '0;
      o_lct       <= 1'b0;
      o_l1a       <= 1'b0;
      o_l1a_match <= 1'b0;
      o_code_err  <= 1'b0;
    end else begin
      r_enc       <= i_enc_trg;
      o_lct       <= w_lct_o;
      o_l1a       <= w_l1a_o;
      o_l1a_match <= w_mtch_o;
      o_code_err  <= w_err;
    end
  end

  // Reset preloads the full stretch so the power-up resync lasts RSY_STRETCH cycles past release;
  // a decoded resync loads one less because its own cycle already counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsy_cnt <= RSY_W'(RSY_STRETCH);
      o_resync  <= 1'b1;
    end else begin
      o_resync <= w_rsy_on;
      if (w_rsy)
        r_rsy_cnt <= RSY_W'(RSY_STRETCH - 1);
      else if (r_rsy_cnt != '0)
        r_rsy_cnt <= r_rsy_cnt - RSY_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist        <= '0;
      o_l1a_cnt     <= '0;
      o_nomatch_cnt <= '0;
    end else if (w_rsy_on) begin
      r_hist        <= '0;
      o_l1a_cnt     <= '0;
      o_nomatch_cnt <= '0;
    end else begin
      r_hist <= {r_hist[MAX_LAT-3:0], w_lct};
      if (w_l1a_o) begin
        o_l1a_cnt <= o_l1a_cnt + CNT_W'(1);
        if (!w_mtch_o && (o_nomatch_cnt != '1))
          o_nomatch_cnt <= o_nomatch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trg_seq_dcd.sv
// Bench for trg_seq_dcd: code-table vectors, hand-written latency/resync/counter sequences and
// randomized traffic checked against a cycle-indexed reference model.
module tb_trg_seq_dcd;

  localparam int MAX_LAT     = 512;
  localparam int LAT_W       = 9;
  localparam int CNT_W       = 12;
  localparam int RSY_STRETCH = 4;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [2:0]       i_enc_trg = 3'd0;
  logic             i_trg_dcd = 1'b1;
  logic             i_local_mtch = 1'b0;
  logic             i_mtch_3bx = 1'b0;
  logic [LAT_W-1:0] i_l1a_lat = '0;
  logic             o_lct, o_l1a, o_l1a_match, o_resync, o_code_err;
  logic [CNT_W-1:0] o_l1a_cnt, o_nomatch_cnt;

  int nChecks = 0;
  int nPass = 0;

  // Reference model state, indexed by edge number since reset release.
  logic [2:0] mPrev;
  int         mN;
  int         mRsyUntil;
  int         mLctTimes[$];
  int         mL1aCnt, mNoCnt;
  logic       mLct, mL1a, mMtch, mRsy, mErr;

  trg_seq_dcd #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .CNT_W(CNT_W), .RSY_STRETCH(RSY_STRETCH)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_enc_trg(i_enc_trg), .i_trg_dcd(i_trg_dcd),
    .i_local_mtch(i_local_mtch), .i_mtch_3bx(i_mtch_3bx), .i_l1a_lat(i_l1a_lat),
    .o_lct(o_lct), .o_l1a(o_l1a), .o_l1a_match(o_l1a_match), .o_resync(o_resync),
    .o_code_err(o_code_err), .o_l1a_cnt(o_l1a_cnt), .o_nomatch_cnt(o_nomatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dcd;
    logic [2:0] enc;
    logic [3:0] expTrg;
    logic       expErr;
  } vec_t;

  vec_t vecs[20];

  // Returns {rsy,mtch,l1a,lct,err} straight from the code tables.
  function automatic logic [4:0] specDecode(logic [2:0] e, logic dcd);
    if (!dcd) return {e[2], e[1], e[1], e[0], 1'b0};
    case (e)
      3'd0: return 5'b00000;
      3'd1: return 5'b00010;
      3'd2: return 5'b00110;
      3'd3: return 5'b01110;
      3'd4: return 5'b00100;
      3'd5: return 5'b01100;
      3'd6: return 5'b00001;
      default: return 5'b10000;
    endcase
  endfunction

  function automatic logic [31:0] dutVec();
    return {3'b0, o_resync, o_l1a_match, o_l1a, o_lct, o_code_err, o_l1a_cnt, o_nomatch_cnt};
  endfunction

  function automatic logic [31:0] modelVec();
    return {3'b0, mRsy, mMtch, mL1a, mLct, mErr, CNT_W'(mL1aCnt), CNT_W'(mNoCnt)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelEdge();
    logic [4:0] d;
    int leff, lo, hi;
    bit loc;
    mN++;
    d = specDecode(mPrev, i_trg_dcd);
    if (d[4]) mRsyUntil = mN + RSY_STRETCH - 1;
    mRsy = (mN <= mRsyUntil);
    mErr = d[0];
    if (mRsy) begin
      mLct = 0; mL1a = 0; mMtch = 0;
      mLctTimes.delete();
      mL1aCnt = 0; mNoCnt = 0;
    end else begin
      if (d[1]) mLctTimes.push_back(mN);
      while (mLctTimes.size() > 0 && mN - mLctTimes[0] > MAX_LAT - 1) void'(mLctTimes.pop_front());
      leff = int'(i_l1a_lat);
      if (leff < 1) leff = 1;
      if (leff > MAX_LAT - 2) leff = MAX_LAT - 2;
      lo = i_mtch_3bx ? leff - 1 : leff;
      hi = i_mtch_3bx ? leff + 1 : leff;
      loc = 0;
      foreach (mLctTimes[i])
        if (mN - mLctTimes[i] >= lo && mN - mLctTimes[i] <= hi) loc = 1;
      mLct = d[1];
      mL1a = d[2];
      mMtch = d[2] & (i_local_mtch ? loc : d[3]);
      if (d[2]) begin
        mL1aCnt = (mL1aCnt + 1) % (1 << CNT_W);
        if (!mMtch && mNoCnt < (1 << CNT_W) - 1) mNoCnt++;
      end
    end
    mPrev = i_enc_trg;
  endtask

  task automatic applyStimulus(input logic [2:0] enc);
    i_enc_trg = enc;
    @(posedge clk);
    #1;
    modelEdge();
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge.
  task automatic doReset();
    i_rst_n = 1'b0;
    i_enc_trg = 3'd0;
    #2;
    checkOutput("reset_state", dutVec(), 32'h1000_0000);
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    mPrev = 3'd0;
    mN = 0;
    mRsyUntil = RSY_STRETCH;
    mLctTimes.delete();
    mL1aCnt = 0;
    mNoCnt = 0;
  endtask

  task automatic gapCase(input string name, input int lat, input bit tbx, input int gap, input bit expM);
    doReset();
    repeat (6) applyStimulus(3'd0);
    i_trg_dcd = 1'b1;
    i_local_mtch = 1'b1;
    i_mtch_3bx = tbx;
    i_l1a_lat = LAT_W'(lat);
    if (gap == 0) applyStimulus(3'd3);
    else begin
      applyStimulus(3'd1);
      repeat (gap - 1) applyStimulus(3'd0);
      applyStimulus(3'd4);
    end
    applyStimulus(3'd0);
    checkOutput({name, "_l1a"}, {30'd0, o_l1a, o_l1a_match}, {30'd0, 1'b1, expM});
    checkOutput({name, "_cnt"}, {8'd0, o_l1a_cnt, o_nomatch_cnt},
                {8'd0, CNT_W'(1), expM ? CNT_W'(0) : CNT_W'(1)});
  endtask

  initial begin
    int highs;
    logic [2:0] enc;
    int r;

    vecs[0]  = '{1'b1, 3'd1, 4'b0000, 1'b0};
    vecs[1]  = '{1'b1, 3'd2, 4'b0001, 1'b0};
    vecs[2]  = '{1'b1, 3'd3, 4'b0011, 1'b0};
    vecs[3]  = '{1'b1, 3'd4, 4'b0111, 1'b0};
    vecs[4]  = '{1'b1, 3'd5, 4'b0010, 1'b0};
    vecs[5]  = '{1'b1, 3'd7, 4'b0110, 1'b0};
    vecs[6]  = '{1'b1, 3'd6, 4'b1000, 1'b0};
    vecs[7]  = '{1'b1, 3'd0, 4'b1000, 1'b1};
    vecs[8]  = '{1'b1, 3'd0, 4'b1000, 1'b0};
    vecs[9]  = '{1'b1, 3'd0, 4'b1000, 1'b0};
    vecs[10] = '{1'b1, 3'd0, 4'b0000, 1'b0};
    vecs[11] = '{1'b0, 3'd3, 4'b0000, 1'b0};
    vecs[12] = '{1'b0, 3'd2, 4'b0111, 1'b0};
    vecs[13] = '{1'b0, 3'd1, 4'b0110, 1'b0};
    vecs[14] = '{1'b0, 3'd6, 4'b0001, 1'b0};
    vecs[15] = '{1'b0, 3'd0, 4'b1000, 1'b0};
    vecs[16] = '{1'b0, 3'd0, 4'b1000, 1'b0};
    vecs[17] = '{1'b0, 3'd0, 4'b1000, 1'b0};
    vecs[18] = '{1'b0, 3'd0, 4'b1000, 1'b0};
    vecs[19] = '{1'b0, 3'd0, 4'b0000, 1'b0};

    #7;
    doReset();
    highs = 0;
    repeat (8) begin
      applyStimulus(3'd0);
      if (o_resync) highs++;
    end
    checkOutput("powerup_rsy_len", 32'(highs), 32'd4);
    checkOutput("powerup_idle", dutVec(), 32'd0);

    for (int i = 0; i < 20; i++) begin
      i_trg_dcd = vecs[i].dcd;
      applyStimulus(vecs[i].enc);
      checkOutput($sformatf("vec%0d", i), {27'd0, o_resync, o_l1a_match, o_l1a, o_lct, o_code_err},
                  {27'd0, vecs[i].expTrg, vecs[i].expErr});
    end

    gapCase("lat100_g100", 100, 1'b0, 100, 1'b1);
    gapCase("lat100_g101", 100, 1'b0, 101, 1'b0);
    gapCase("w3_g98",  100, 1'b1, 98,  1'b0);
    gapCase("w3_g99",  100, 1'b1, 99,  1'b1);
    gapCase("w3_g100", 100, 1'b1, 100, 1'b1);
    gapCase("w3_g101", 100, 1'b1, 101, 1'b1);
    gapCase("w3_g102", 100, 1'b1, 102, 1'b0);
    gapCase("lat0_g1", 0, 1'b0, 1, 1'b1);
    gapCase("lat0_g2", 0, 1'b0, 2, 1'b0);
    gapCase("lat511_g510", 511, 1'b0, 510, 1'b1);
    gapCase("lat511_g511", 511, 1'b0, 511, 1'b0);
    gapCase("dist0_w3", 1, 1'b1, 0, 1'b1);
    gapCase("dist0_exact", 1, 1'b0, 0, 1'b0);

    // Resync between an LCT and its L1A wipes the history; a second resync extends the stretch.
    doReset();
    repeat (6) applyStimulus(3'd0);
    i_trg_dcd = 1'b1; i_local_mtch = 1'b1; i_mtch_3bx = 1'b0; i_l1a_lat = LAT_W'(100);
    applyStimulus(3'd1);
    repeat (49) applyStimulus(3'd0);
    applyStimulus(3'd7);
    applyStimulus(3'd0);
    checkOutput("rsy_mid_hold", {7'd0, o_resync, o_l1a_cnt, o_nomatch_cnt}, {7'd0, 1'b1, 24'd0});
    repeat (48) applyStimulus(3'd0);
    applyStimulus(3'd4);
    applyStimulus(3'd0);
    checkOutput("rsy_mid_l1a", {7'd0, o_l1a_match, o_l1a_cnt, o_nomatch_cnt},
                {7'd0, 1'b0, CNT_W'(1), CNT_W'(1)});
    highs = 0;
    applyStimulus(3'd7);
    applyStimulus(3'd0);
    if (o_resync) highs++;
    applyStimulus(3'd7);
    if (o_resync) highs++;
    repeat (10) begin
      applyStimulus(3'd0);
      if (o_resync) highs++;
    end
    checkOutput("rsy_extend_len", 32'(highs), 32'd6);

    doReset();
    repeat (6) applyStimulus(3'd0);
    i_trg_dcd = 1'b1; i_local_mtch = 1'b0;
    repeat (4096) applyStimulus(3'd4);
    checkOutput("cnt_4095", {8'd0, o_l1a_cnt, o_nomatch_cnt}, {8'd0, CNT_W'(4095), CNT_W'(4095)});
    applyStimulus(3'd0);
    checkOutput("cnt_wrap", {8'd0, o_l1a_cnt, o_nomatch_cnt}, {8'd0, CNT_W'(0), CNT_W'(4095)});
    repeat (4) applyStimulus(3'd4);
    applyStimulus(3'd0);
    checkOutput("cnt_sat", {8'd0, o_l1a_cnt, o_nomatch_cnt}, {8'd0, CNT_W'(4), CNT_W'(4095)});

    doReset();
    for (int seg = 0; seg < 8; seg++) begin
      if (seg == 4) doReset();
      i_trg_dcd = (seg % 4 != 3);
      i_local_mtch = 1'($urandom_range(0, 1));
      i_mtch_3bx = 1'($urandom_range(0, 1));
      i_l1a_lat = (seg == 5) ? LAT_W'(511) : LAT_W'($urandom_range(0, 10));
      repeat (300) begin
        r = $urandom_range(0, 99);
        if (i_trg_dcd)
          enc = (r < 50) ? 3'd0 : (r < 65) ? 3'd1 : (r < 75) ? 3'd4 : (r < 82) ? 3'd2 :
                (r < 88) ? 3'd3 : (r < 94) ? 3'd5 : (r < 97) ? 3'd6 : 3'd7;
        else
          enc = (r < 98) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
        if (r == 42) i_l1a_lat = LAT_W'($urandom_range(0, 10));
        applyStimulus(enc);
        checkOutput("rand", dutVec(), modelVec());
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
